// File: rtl/selector_pkg.sv
// Shared types and constants for the selector encode/decode path.
// Holds the per-group reduction record and the stage-indexing helpers.
package selector_pkg;

   localparam int SEL_ADDR_W  = 8;
   localparam int SEL_POS_W   = 256;
   localparam int SEL_DIGIT_W = 2;
   localparam int SEL_RADIX   = 4;

   // The prefix holds the digits resolved so far; bits above the current stage stay zero.
   typedef struct packed {
      logic                  any;
      logic                  multi;
      logic [SEL_ADDR_W-1:0] prefix;
   } sel_rec_t;

   // Number of records produced by stage s (0-based).
   function automatic int stage_groups(input int s, input int pos_w);
      return pos_w >> (SEL_DIGIT_W * (s + 1));
   endfunction

   // Offset of stage s inside the flat record array holding every stage back to back.
   function automatic int stage_off(input int s, input int pos_w);
      int o;
      o = 0;
      for (int i = 0; i < s; i++) o += stage_groups(i, pos_w);
      return o;
   endfunction

endpackage

// File: rtl/selector_encode_8_encode_4.sv
// Combinational 4-to-1 record reducer: picks the lowest child with any set
// and flags collisions between children or inside any child.
module encode_4
   import selector_pkg::*;
(
   input  sel_rec_t [SEL_RADIX-1:0]   child,
   output sel_rec_t                   rec,
   output logic     [SEL_DIGIT_W-1:0] digit
);

   logic [SEL_RADIX-1:0] any_v;
   logic                 pair;

   always_comb begin
      any_v = '0;
      pair  = 1'b0;
      digit = '0;
      rec   = '0;
      for (int c = 0; c < SEL_RADIX; c++) any_v[c] = child[c].any;
      // Scan downward so the lowest set child is the last one written.
      for (int c = SEL_RADIX - 1; c >= 0; c--) begin
         if (any_v[c]) digit = SEL_DIGIT_W'(c);
      end
      for (int i = 0; i < SEL_RADIX; i++) begin
         for (int j = i + 1; j < SEL_RADIX; j++) pair = pair | (any_v[i] & any_v[j]);
      end
      rec.any   = |any_v;
      rec.multi = pair;
      for (int c = 0; c < SEL_RADIX; c++) rec.multi = rec.multi | child[c].multi;
      rec.prefix = rec.any ? child[digit].prefix : '0;
   end

endmodule

// File: rtl/selector_encode_8.sv
// Pipelined positional-to-binary encoder: one base-4 address digit per stage,
// least-significant first, under a single global advance enable.
module selector_encode_8
   import selector_pkg::*;
#(
   parameter  int ADDR_W = SEL_ADDR_W,
   localparam int POS_W  = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [POS_W-1:0]  in_positional,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_none,
   output logic              out_multi,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int STAGES = ADDR_W / SEL_DIGIT_W;
   localparam int TOTAL  = stage_off(STAGES, POS_W);

   sel_rec_t          rec_d [TOTAL];
   sel_rec_t          rec_q [TOTAL];
   logic [STAGES-1:0] vld_q;
   logic              adv;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int N    = stage_groups(s, POS_W);
      localparam int OFF  = stage_off(s, POS_W);
      localparam int PREV = (s == 0) ? 0 : stage_off(s - 1, POS_W);
      localparam int SH   = SEL_DIGIT_W * s;

      for (genvar g = 0; g < N; g++) begin : g_group
         sel_rec_t [SEL_RADIX-1:0]   child;
         sel_rec_t                   red;
         logic     [SEL_DIGIT_W-1:0] digit;

         for (genvar c = 0; c < SEL_RADIX; c++) begin : g_child
            if (s == 0) begin : g_raw
               assign child[c] = '{any: in_positional[SEL_RADIX*g+c], multi: 1'b0, prefix: '0};
            end else begin : g_rec
               assign child[c] = rec_q[PREV+SEL_RADIX*g+c];
            end
         end

         encode_4 u_enc (
            .child (child),
            .rec   (red),
            .digit (digit)
         );

         // New digit lands above the digits already carried by the chosen child.
         assign rec_d[OFF+g] = '{any:    red.any,
                                 multi:  red.multi,
                                 prefix: red.prefix | (SEL_ADDR_W'(digit) << SH)};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < TOTAL; i++) rec_q[i] <= '0;
      end else if (adv) begin
         vld_q <= (vld_q << 1) | {{(STAGES-1){1'b0}}, in_valid};
         rec_q <= rec_d;
      end
   end

   assign adv       = out_ready | ~vld_q[STAGES-1];
   assign in_ready  = adv;
   assign out_valid = vld_q[STAGES-1];
   assign out_addr  = rec_q[TOTAL-1].prefix[ADDR_W-1:0];
   assign out_none  = out_valid & ~rec_q[TOTAL-1].any;
   assign out_multi = rec_q[TOTAL-1].multi;

endmodule

// File: tb/tb_selector_encode_8.sv
// Directed bench for selector_encode_8: latency, flags, streaming, stall and reset.
module tb_selector_encode_8;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] in_positional;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   out_addr;
   logic         out_none;
   logic         out_multi;
   logic         out_valid;
   logic         out_ready;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [9:0]  exp_q[$];
   logic        acc;

   always #5 clk = ~clk;

   selector_encode_8 dut (
      .clk           (clk),
      .rst           (rst),
      .in_positional (in_positional),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .out_addr      (out_addr),
      .out_none      (out_none),
      .out_multi     (out_multi),
      .out_valid     (out_valid),
      .out_ready     (out_ready)
   );

   function automatic logic [255:0] onehot(input int n);
      logic [255:0] v;
      v    = '0;
      v[n] = 1'b1;
      return v;
   endfunction

   // Expected record packed as {none, multi, addr}.
   function automatic logic [9:0] mk(input int a, input logic none, input logic multi);
      return {none, multi, 8'(a)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock of traffic; scoreboard pops on output handshake, pushes on acceptance.
   task automatic step(input logic v, input logic [255:0] vec, input logic rdy,
                       input logic [9:0] e, output logic accepted);
      in_valid      = v;
      in_positional = vec;
      out_ready     = rdy;
      #1;
      accepted = in_valid & in_ready;
      if (out_valid && out_ready) begin
         n_cmp++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_out: observed addr %0d expected no output", out_addr);
         end
         if (exp_q.size() != 0) chk("out_rec", {22'd0, out_none, out_multi, out_addr}, {22'd0, exp_q.pop_front()});
      end
      if (accepted) exp_q.push_back(e);
      tick();
   endtask

   task automatic drain(input int budget);
      logic a;
      for (int i = 0; i < budget && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1, '0, a);
      chk("drain_empty", exp_q.size(), 0);
   endtask

   // Accept one vector and check it appears exactly after the third following edge.
   task automatic lat_check(input int a);
      in_valid      = 1'b1;
      in_positional = onehot(a);
      out_ready     = 1'b1;
      #1;
      chk("lat_in_ready", in_ready, 1);
      tick();
      in_valid      = 1'b0;
      in_positional = '0;
      tick();
      chk("lat_ov_k1", out_valid, 0);
      tick();
      chk("lat_ov_k2", out_valid, 0);
      tick();
      chk("lat_ov_k3", out_valid, 1);
      chk("lat_addr", out_addr, a);
      chk("lat_none", out_none, 0);
      chk("lat_multi", out_multi, 0);
      tick();
      chk("lat_pulse_end", out_valid, 0);
   endtask

   initial begin
      int list [5];
      list = '{10, 20, 30, 40, 50};

      rst           = 1'b1;
      in_valid      = 1'b0;
      in_positional = '0;
      out_ready     = 1'b1;
      tick();
      tick();
      chk("rst_ov", out_valid, 0);
      chk("rst_addr", out_addr, 0);
      chk("rst_none", out_none, 0);
      chk("rst_multi", out_multi, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      tick();

      lat_check(165);

      step(1'b1, '0, 1'b1, mk(0, 1'b1, 1'b0), acc);
      step(1'b1, onehot(3) | onehot(200), 1'b1, mk(3, 1'b0, 1'b1), acc);
      step(1'b1, onehot(255), 1'b1, mk(255, 1'b0, 1'b0), acc);
      step(1'b1, onehot(64) | onehot(65), 1'b1, mk(64, 1'b0, 1'b1), acc);
      step(1'b1, 256'hF0, 1'b1, mk(4, 1'b0, 1'b1), acc);
      step(1'b1, {256{1'b1}}, 1'b1, mk(0, 1'b0, 1'b1), acc);
      step(1'b1, onehot(128), 1'b1, mk(128, 1'b0, 1'b0), acc);
      step(1'b1, onehot(0), 1'b1, mk(0, 1'b0, 1'b0), acc);
      drain(10);

      for (int i = 0; i < 256; i++) begin
         step(1'b1, onehot(i), 1'b1, mk(i, 1'b0, 1'b0), acc);
         chk("stream_acc", acc, 1);
         if (i >= 3) chk("stream_ov", out_valid, 1);
      end
      drain(10);

      for (int k = 0; k < 4; k++) begin
         step(1'b1, onehot(list[k]), 1'b0, mk(list[k], 1'b0, 1'b0), acc);
         chk("fill_acc", acc, 1);
      end
      chk("full_ov", out_valid, 1);
      chk("full_addr", out_addr, 10);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, onehot(list[4]), 1'b0, mk(list[4], 1'b0, 1'b0), acc);
         chk("stall_in_ready", acc, 0);
         chk("stall_ov", out_valid, 1);
         chk("stall_addr", out_addr, 10);
      end
      step(1'b1, onehot(list[4]), 1'b1, mk(list[4], 1'b0, 1'b0), acc);
      chk("release_acc", acc, 1);
      drain(10);

      step(1'b1, onehot(77), 1'b1, mk(77, 1'b0, 1'b0), acc);
      step(1'b1, onehot(88), 1'b1, mk(88, 1'b0, 1'b0), acc);
      rst           = 1'b1;
      in_valid      = 1'b1;
      in_positional = onehot(99);
      out_ready     = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      chk("rst2_ov", out_valid, 0);
      chk("rst2_addr", out_addr, 0);
      chk("rst2_none", out_none, 0);
      chk("rst2_multi", out_multi, 0);
      chk("rst2_in_ready", in_ready, 1);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, '0, acc);
      lat_check(8'h3C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
